// File: rtl/piano_pkg.sv
// Shared definitions for the FPGA piano blocks.
//   - note codes produced by the keyboard decoder (0 = no key held)
//   - note_led(): one-hot LED hint for a note code
//   - tutor_state_e: song tutor control states
package piano_pkg;

    localparam int unsigned NOTE_NONE = 0;
    localparam int unsigned NOTE_C4   = 1;
    localparam int unsigned NOTE_D    = 2;
    localparam int unsigned NOTE_E    = 3;
    localparam int unsigned NOTE_F    = 4;
    localparam int unsigned NOTE_G    = 5;
    localparam int unsigned NOTE_A    = 6;
    localparam int unsigned NOTE_B    = 7;
    localparam int unsigned NOTE_C5   = 8;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PRESS,
        ST_RELEASE,
        ST_DONE
    } tutor_state_e;

    // Bit (code-1) set; zero for NOTE_NONE or a code beyond the LED bus.
    function automatic logic [31:0] note_led(input int unsigned code,
                                             input int unsigned led_w);
        logic [31:0] r;
        r = '0;
        if (code != NOTE_NONE && code <= led_w && code <= 32)
            r = 32'd1 << (code - 1);
        return r;
    endfunction

endpackage

// File: rtl/song_rom.sv
// Combinational melody ROM.
//   song  : song number
//   index : note position within the song
//   note  : note code at that position (NOTE_NONE past the end)
//   len   : number of notes in the song (1..MAX_LEN)
// Song 0 = Ode to Joy (15), song 1 = C major scale (8), others = single C4.
module song_rom
    import piano_pkg::*;
#(
    parameter int NOTE_W    = 4,
    parameter int MAX_LEN   = 32,
    parameter int NUM_SONGS = 4,
    parameter int SEL_W     = 2,
    parameter int IDX_W     = 6
) (
    input  logic [SEL_W-1:0] song,
    input  logic [IDX_W-1:0] index,
    output logic [NOTE_W-1:0] note,
    output logic [IDX_W-1:0]  len
);

    function automatic int unsigned ode_note(input int unsigned i);
        case (i)
            0, 1, 6, 11, 12: return NOTE_E;
            2, 5:            return NOTE_F;
            3, 4:            return NOTE_G;
            7, 10, 13, 14:   return NOTE_D;
            8, 9:            return NOTE_C4;
            default:         return NOTE_NONE;
        endcase
    endfunction

    int unsigned idx_i;
    int unsigned note_i;
    int unsigned len_i;

    always_comb begin
        idx_i  = 32'(index);
        note_i = NOTE_C4;
        len_i  = 1;
        if (NUM_SONGS > 0 && song == SEL_W'(0)) begin
            note_i = ode_note(idx_i);
            len_i  = 15;
        end else if (NUM_SONGS > 1 && song == SEL_W'(1)) begin
            note_i = NOTE_C4 + idx_i;
            len_i  = 8;
        end
        if (len_i > MAX_LEN)
            len_i = MAX_LEN;
        if (idx_i >= len_i)
            note_i = NOTE_NONE;
        note = NOTE_W'(note_i);
        len  = IDX_W'(len_i);
    end

endmodule

// File: rtl/song_tutor.sv
// Song tutor: walks the player through a stored melody note by note.
//   CLK, RESET : clock, asynchronous active-high reset
//   note       : key code from the piano decoder (0 = none)
//   start      : pulse, (re)start song song_sel
//   song_sel   : song number, sampled on start
//   Led        : hint of expected note, all ones when done
//   index      : notes completed
//   mistakes   : wrong presses since start (saturating)
//   busy       : waiting for a press or release
//   done       : one-cycle pulse on completion
//   stale      : player idle for TIMEOUT_CYC cycles on the current note
module song_tutor
    import piano_pkg::*;
#(
    parameter int NOTE_W      = 4,
    parameter int LED_W       = 8,
    parameter int MAX_LEN     = 32,
    parameter int NUM_SONGS   = 4,
    parameter int MISS_W      = 8,
    parameter int STRICT      = 0,
    parameter int AUTO_LOOP   = 0,
    parameter int TIMEOUT_CYC = 0,
    localparam int IDX_W      = $clog2(MAX_LEN + 1),
    localparam int SEL_W      = (NUM_SONGS > 1) ? $clog2(NUM_SONGS) : 1
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic [NOTE_W-1:0] note,
    input  logic              start,
    input  logic [SEL_W-1:0]  song_sel,
    output logic [LED_W-1:0]  Led,
    output logic [IDX_W-1:0]  index,
    output logic [MISS_W-1:0] mistakes,
    output logic              busy,
    output logic              done,
    output logic              stale
);

    localparam int CNT_W = (TIMEOUT_CYC < 1) ? 1 : $clog2(TIMEOUT_CYC + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYC);

    tutor_state_e      state_q, state_d;
    logic [SEL_W-1:0]  song_q, song_d;
    logic [IDX_W-1:0]  index_q, index_d;
    logic [MISS_W-1:0] mistakes_q, mistakes_d;
    logic              good_q, good_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [NOTE_W-1:0] exp_q, exp_d;
    logic [IDX_W-1:0]  len_q, len_d;
    logic [LED_W-1:0]  led_q, led_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              stale_q, stale_d;

    logic [NOTE_W-1:0] rom_note;
    logic [IDX_W-1:0]  rom_len;
    logic [IDX_W-1:0]  idx_inc;

    // The ROM is looked up at the next-state song/index so the LED hint
    // lands on the same edge as the state; the result is also registered
    // as the expected note/length used while in that state.
    song_rom #(
        .NOTE_W    (NOTE_W),
        .MAX_LEN   (MAX_LEN),
        .NUM_SONGS (NUM_SONGS),
        .SEL_W     (SEL_W),
        .IDX_W     (IDX_W)
    ) u_rom (
        .song  (song_d),
        .index (index_d),
        .note  (rom_note),
        .len   (rom_len)
    );

    assign idx_inc = index_q + IDX_W'(1);

    always_comb begin
        state_d    = state_q;
        song_d     = song_q;
        index_d    = index_q;
        mistakes_d = mistakes_q;
        good_d     = good_q;
        cnt_d      = cnt_q;
        done_d     = 1'b0;
        if (start) begin
            state_d    = ST_PRESS;
            song_d     = song_sel;
            index_d    = '0;
            mistakes_d = '0;
            good_d     = 1'b0;
            cnt_d      = '0;
        end else begin
            case (state_q)
                ST_IDLE: ;
                ST_PRESS: begin
                    if (note == '0) begin
                        if (cnt_q != CNT_MAX)
                            cnt_d = cnt_q + CNT_W'(1);
                    end else begin
                        cnt_d   = '0;
                        state_d = ST_RELEASE;
                        good_d  = (note == exp_q);
                        if (note != exp_q) begin
                            if (mistakes_q != '1)
                                mistakes_d = mistakes_q + MISS_W'(1);
                            if (STRICT != 0)
                                index_d = '0;
                        end
                    end
                end
                ST_RELEASE: begin
                    if (note == '0) begin
                        cnt_d   = '0;
                        state_d = ST_PRESS;
                        if (good_q) begin
                            index_d = idx_inc;
                            if (idx_inc == len_q) begin
                                state_d = ST_DONE;
                                done_d  = 1'b1;
                            end
                        end
                    end
                end
                ST_DONE: begin
                    if (AUTO_LOOP != 0) begin
                        state_d = ST_PRESS;
                        index_d = '0;
                        cnt_d   = '0;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        exp_d   = rom_note;
        len_d   = rom_len;
        busy_d  = (state_d == ST_PRESS) || (state_d == ST_RELEASE);
        stale_d = (TIMEOUT_CYC != 0) && (state_d == ST_PRESS) && (cnt_d >= CNT_MAX);
        case (state_d)
            ST_IDLE: led_d = '0;
            ST_DONE: led_d = '1;
            default: led_d = LED_W'(note_led(32'(rom_note), LED_W));
        endcase
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q    <= ST_IDLE;
            song_q     <= '0;
            index_q    <= '0;
            mistakes_q <= '0;
            good_q     <= 1'b0;
            cnt_q      <= '0;
            exp_q      <= '0;
            len_q      <= '0;
            led_q      <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            stale_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            song_q     <= song_d;
            index_q    <= index_d;
            mistakes_q <= mistakes_d;
            good_q     <= good_d;
            cnt_q      <= cnt_d;
            exp_q      <= exp_d;
            len_q      <= len_d;
            led_q      <= led_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            stale_q    <= stale_d;
        end
    end

    assign Led      = led_q;
    assign index    = index_q;
    assign mistakes = mistakes_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign stale    = stale_q;

endmodule
